// File: rtl/m_cycle_sequencer.sv
// rtl/m_cycle_sequencer.sv - T-step / M-cycle timing generator with fetch and HALT control.
// Optional instruction-length profiling: define M_CYCLE_SEQUENCER_PROFILE_EN.
module m_cycle_sequencer #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Enable,
  input  logic                   i_IR_Fetch,
  input  logic                   i_Halt_Req,
  input  logic                   i_Wake,
  output logic [3:0]             o_Cycle_Step,
  output logic [COUNT_WIDTH-1:0] o_Cycle_Count,
  output logic                   o_IR_Load,
  output logic                   o_Fetch_Only,
  output logic                   o_Halted,
  output logic                   o_Sequence_Error
`ifdef M_CYCLE_SEQUENCER_PROFILE_EN
  ,
  output logic [3:0]             o_Last_Length
`endif
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] LP_M1 = COUNT_WIDTH'(1);

  state_t                  r_state, w_state_next;
  logic [3:0]              r_step, w_step_next;
  logic [COUNT_WIDTH-1:0]  r_count, w_count_next;
  logic                    r_ir_load, w_ir_load_next;
  logic                    r_error, w_error_next;
  logic                    w_boundary;

  assign w_boundary = i_Enable & r_step[3];

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state   <= S_FETCH;
      r_step    <= 4'b0001;
      r_count   <= '0;
      r_ir_load <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_step    <= w_step_next;
      r_count   <= w_count_next;
      r_ir_load <= w_ir_load_next;
      r_error   <= w_error_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_step_next    = r_step;
    w_count_next   = r_count;
    w_ir_load_next = r_ir_load;
    w_error_next   = r_error;
    if (i_Enable) begin
      w_step_next    = {r_step[2:0], r_step[3]};
      w_ir_load_next = 1'b0;
    end
    // Control inputs only matter on the T4 clock that closes an M-cycle.
    if (w_boundary) begin
      case (r_state)
        S_FETCH: begin
          w_ir_load_next = 1'b1;
          w_count_next   = LP_M1;
          w_state_next   = S_RUN;
        end
        S_RUN: begin
          if (i_Halt_Req) begin
            w_state_next = S_HALTED;
            w_count_next = '0;
          end else if (i_IR_Fetch) begin
            w_ir_load_next = 1'b1;
            w_count_next   = LP_M1;
          end else if (r_count[COUNT_WIDTH-1]) begin
            w_count_next = '0;
            w_state_next = S_FETCH;
            w_error_next = 1'b1;
          end else begin
            w_count_next = {r_count[COUNT_WIDTH-2:0], 1'b0};
          end
        end
        S_HALTED: begin
          w_count_next = '0;
          if (i_Wake) w_state_next = S_FETCH;
        end
        default: begin
          w_state_next = S_FETCH;
          w_count_next = '0;
        end
      endcase
    end
  end

`ifdef M_CYCLE_SEQUENCER_PROFILE_EN
  // r_len counts M-cycles of the running instruction, saturating at 15.
  logic [3:0] r_len;
  logic [3:0] r_last;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_len  <= 4'd0;
      r_last <= 4'd0;
    end else if (w_boundary && r_state == S_FETCH) begin
      r_len <= 4'd1;
    end else if (w_boundary && r_state == S_RUN && !i_Halt_Req) begin
      if (i_IR_Fetch) begin
        r_last <= r_len;
        r_len  <= 4'd1;
      end else if (r_len != 4'd15) begin
        r_len <= r_len + 4'd1;
      end
    end
  end

  assign o_Last_Length = r_last;
`endif

  assign o_Cycle_Step     = r_step;
  assign o_Cycle_Count    = r_count;
  assign o_IR_Load        = r_ir_load & i_Enable;
  assign o_Fetch_Only     = (r_state == S_FETCH);
  assign o_Halted         = (r_state == S_HALTED);
  assign o_Sequence_Error = r_error;

endmodule

// File: tb/tb_m_cycle_sequencer.sv
// tb/tb_m_cycle_sequencer.sv - directed and randomized checks of m_cycle_sequencer against a reference model.
module tb_m_cycle_sequencer;
  localparam int CW = 8;

  logic          i_Clk = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_Enable = 1'b1;
  logic          i_IR_Fetch = 1'b0;
  logic          i_Halt_Req = 1'b0;
  logic          i_Wake = 1'b0;
  logic [3:0]    o_Cycle_Step;
  logic [CW-1:0] o_Cycle_Count;
  logic          o_IR_Load;
  logic          o_Fetch_Only;
  logic          o_Halted;
  logic          o_Sequence_Error;
`ifdef M_CYCLE_SEQUENCER_PROFILE_EN
  logic [3:0]    o_Last_Length;
`endif

  m_cycle_sequencer #(.COUNT_WIDTH(CW)) dut (
    .i_Clk(i_Clk),
    .i_Reset(i_Reset),
    .i_Enable(i_Enable),
    .i_IR_Fetch(i_IR_Fetch),
    .i_Halt_Req(i_Halt_Req),
    .i_Wake(i_Wake),
    .o_Cycle_Step(o_Cycle_Step),
    .o_Cycle_Count(o_Cycle_Count),
    .o_IR_Load(o_IR_Load),
    .o_Fetch_Only(o_Fetch_Only),
    .o_Halted(o_Halted),
    .o_Sequence_Error(o_Sequence_Error)
`ifdef M_CYCLE_SEQUENCER_PROFILE_EN
    ,
    .o_Last_Length(o_Last_Length)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: T index 0..3, mode (0 fetch, 1 run, 2 halted), M-cycle number (0 = none).
  int ph, md, mc, irl, err, last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clock();
    if (i_Reset) begin
      ph = 0; md = 0; mc = 0; irl = 0; err = 0; last = 0;
    end else if (i_Enable) begin
      irl = 0;
      if (ph == 3) begin
        if (md == 0) begin
          irl = 1; mc = 1; md = 1;
        end else if (md == 1) begin
          if (i_Halt_Req) begin
            md = 2; mc = 0;
          end else if (i_IR_Fetch) begin
            irl = 1; last = (mc > 15) ? 15 : mc; mc = 1;
          end else if (mc == CW) begin
            mc = 0; md = 0; err = 1;
          end else begin
            mc = mc + 1;
          end
        end else if (i_Wake) begin
          md = 0;
        end
      end
      ph = (ph + 1) % 4;
    end
  endtask

  task automatic compare_all();
    chk("step", 32'(o_Cycle_Step), 32'd1 << ph);
    chk("count", 32'(o_Cycle_Count), (mc == 0) ? 32'd0 : (32'd1 << (mc - 1)));
    chk("ir_load", 32'(o_IR_Load), 32'((irl != 0) && i_Enable));
    chk("fetch_only", 32'(o_Fetch_Only), 32'(md == 0));
    chk("halted", 32'(o_Halted), 32'(md == 2));
    chk("seq_error", 32'(o_Sequence_Error), 32'(err));
`ifdef M_CYCLE_SEQUENCER_PROFILE_EN
    chk("last_length", 32'(o_Last_Length), 32'(last));
`endif
  endtask

  task automatic tick();
    @(posedge i_Clk);
    model_clock();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    i_Reset = 1'b0; i_Enable = 1'b1; i_IR_Fetch = 1'b0; i_Halt_Req = 1'b0; i_Wake = 1'b0;
  endtask

  initial begin
    ph = 0; md = 0; mc = 0; irl = 0; err = 0; last = 0;
    #2;
    tick();
    chk("reset_step", 32'(o_Cycle_Step), 32'h1);
    chk("reset_count", 32'(o_Cycle_Count), 32'h0);
    chk("reset_fetch_only", 32'(o_Fetch_Only), 32'h1);
    idle_inputs();

    for (int k = 0; k < 4; k++) tick();
    chk("first_ir_load", 32'(o_IR_Load), 32'h1);
    chk("first_count", 32'(o_Cycle_Count), 32'h1);
    chk("first_step", 32'(o_Cycle_Step), 32'h1);

    // Two-M-cycle instructions back to back.
    for (int k = 0; k < 24; k++) begin
      i_IR_Fetch = (mc == 2);
      tick();
    end
    i_IR_Fetch = 1'b0;
`ifdef M_CYCLE_SEQUENCER_PROFILE_EN
    chk("profile_len2", 32'(o_Last_Length), 32'd2);
`endif

    // Freeze at T3.
    for (int k = 0; k < 8 && ph != 2; k++) tick();
    i_Enable = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("frozen_step", 32'(o_Cycle_Step), 32'h4);
    i_Enable = 1'b1;

    // Halt and fetch together in M1, then wake only at T2, then held wake.
    for (int k = 0; k < 200 && !(md == 1 && mc == 1 && ph == 3); k++) begin
      i_IR_Fetch = (md == 1 && mc >= 2);
      tick();
    end
    chk("reach_m1_t4", 32'(md == 1 && mc == 1 && ph == 3), 32'd1);
    i_IR_Fetch = 1'b1; i_Halt_Req = 1'b1;
    tick();
    i_IR_Fetch = 1'b0; i_Halt_Req = 1'b0;
    chk("halt_entered", 32'(o_Halted), 32'h1);
    chk("halt_no_load", 32'(o_IR_Load), 32'h0);
    for (int k = 0; k < 4; k++) begin
      i_Wake = (ph == 1);
      tick();
    end
    i_Wake = 1'b0;
    chk("wake_t2_ignored", 32'(o_Halted), 32'h1);
    i_Wake = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    i_Wake = 1'b0;
    chk("wake_to_fetch", 32'(o_Fetch_Only), 32'h1);
    for (int k = 0; k < 4; k++) tick();
    chk("wake_ir_load", 32'(o_IR_Load), 32'h1);

    // Overflow with no fetch.
    for (int k = 0; k < 4 * CW; k++) tick();
    chk("overflow_error", 32'(o_Sequence_Error), 32'h1);
    chk("overflow_fetch", 32'(o_Fetch_Only), 32'h1);
    for (int k = 0; k < 20; k++) tick();
    chk("overflow_sticky", 32'(o_Sequence_Error), 32'h1);

    // Reset mid-instruction at T3 of M3.
    for (int k = 0; k < 100 && !(md == 1 && mc == 3 && ph == 2); k++) tick();
    chk("reach_m3_t3", 32'(md == 1 && mc == 3 && ph == 2), 32'd1);
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    chk("midreset_step", 32'(o_Cycle_Step), 32'h1);
    chk("midreset_count", 32'(o_Cycle_Count), 32'h0);
    chk("midreset_error", 32'(o_Sequence_Error), 32'h0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      i_Enable   = ($urandom_range(0, 9) < 8);
      i_Reset    = ($urandom_range(0, 299) == 0);
      i_Halt_Req = ($urandom_range(0, 19) == 0);
      i_IR_Fetch = ($urandom_range(0, 4) == 0);
      i_Wake     = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/m_cycle_sequencer.md
Name: m_cycle_sequencer

Overview:
- Timing generator for the CPU control unit.
- Produces the one-hot T-step (i_Cycle_Step) and one-hot M-cycle (i_Cycle_Count) buses consumed by every per-opcode microcode block.
- Consumes the OR-ed IR_Fetch of those blocks to terminate an instruction, load the next opcode and restart at M1.
- Also owns power-on opcode fetch and HALT idling.

Parameters:
- COUNT_WIDTH, 8, width of one-hot M-cycle bus; max instruction length in M-cycles.

Ports:
- i_Clk  input  1  system clock.
- i_Reset  input  1  synchronous, active-high reset.
- i_Enable  input  1  clock enable; low freezes all state and suppresses pulses.
- i_IR_Fetch  input  1  OR of all microcode o_IR_Fetch; current M-cycle is the instruction's last.
- i_Halt_Req  input  1  HALT microcode requests halt at end of current M-cycle.
- i_Wake  input  1  interrupt pending; exits HALTED.
- o_Cycle_Step  output  4  one-hot T-step T1..T4 (bit0=T1).
- o_Cycle_Count  output  COUNT_WIDTH  one-hot M-cycle within instruction; all-zero when no instruction is active.
- o_IR_Load  output  1  one-clock pulse: latch data bus into IR.
- o_Fetch_Only  output  1  high in FETCH state; datapath drives PC address and increments PC.
- o_Halted  output  1  high in HALTED state.
- o_Sequence_Error  output  1  sticky: M-cycle count overflowed.

Behaviour:
- State register has three states: FETCH, RUN, HALTED.
- Reset values: state FETCH, o_Cycle_Step=0001, o_Cycle_Count=0, o_IR_Load=0, o_Halted=0, o_Sequence_Error=0. o_Fetch_Only=1, since it decodes FETCH.
- All updates occur only on rising i_Clk with i_Enable=1. Reset overrides i_Enable.
- T-step: rotates left on every enabled clock in all states: 0001→0010→0100→1000→0001.
- M-cycle boundary: an enabled clock while o_Cycle_Step[3]=1. All transitions below occur only at boundaries.
- Inputs i_IR_Fetch, i_Halt_Req and i_Wake are sampled only at the boundary clock. They are combinational from the current M-cycle.
- FETCH:
  - o_Cycle_Count=0 for the whole M-cycle.
  - At boundary: o_IR_Load pulses (registered; high during the following T1 clock), count becomes 00000001, state becomes RUN.
- RUN, at boundary, in priority order:
  1. i_Halt_Req=1 → state HALTED, count=0, no IR_Load.
  2. i_IR_Fetch=1 → IR_Load pulse, count=00000001, stay RUN. The opcode was fetched by the overlapping last M-cycle.
  3. Otherwise count shifts left one bit.
- Overflow: in RUN, if count MSB=1 at boundary with neither request:
  - count wraps to 0, state FETCH, o_Sequence_Error set.
  - The flag stays set until reset.
- HALTED:
  - count=0, o_Halted=1, steps keep rotating.
  - At boundary with i_Wake=1 → FETCH.
  - i_Wake outside a boundary is ignored until the next boundary.
- Simultaneous events:
  - Halt beats fetch.
  - i_Wake in RUN or FETCH is ignored.
  - i_IR_Fetch in FETCH or HALTED is ignored.
- Latency: instruction of N M-cycles occupies exactly 4·N enabled clocks from IR_Load to next IR_Load.
- Reset mid-instruction: next clock state FETCH, step 0001, count 0; any pending IR_Load pulse is cancelled.
- i_Enable low on the boundary clock: the boundary is deferred; the pulse fires on the first enabled T4 clock.

Optional Feature:
- Macro M_CYCLE_SEQUENCER_PROFILE_EN.
- When defined:
  - Adds output o_Last_Length [3:0], reset 0: number of M-cycles of the most recently completed instruction, counting from its M1 through the IR_Fetch cycle.
  - Updated with each IR_Load that follows a RUN instruction; saturates at 15.
  - Halt or overflow leaves it unchanged.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then 4 enabled clocks → step 0001,0010,0100,1000; count 0; o_Fetch_Only=1. 5th clock: o_IR_Load=1, count=00000001, step=0001.
- RUN, i_IR_Fetch high only while count=00000010 → count 01→02→01 across 8 clocks; IR_Load pulses every 8 clocks. PROFILE_EN: o_Last_Length=2.
- i_Enable low for 3 clocks at step 0100 → step and count frozen, no pulses; resumes with 1000 then boundary.
- RUN count=00000001, i_Halt_Req and i_IR_Fetch both high at T4 → HALTED, count 0, no IR_Load. i_Wake at T2 → exit only at next boundary into FETCH, then IR_Load 4 clocks later.
- RUN with no fetch for 8 M-cycles → at count 10000000 boundary: state FETCH, count 0, o_Sequence_Error=1, still 1 after a further 20 clocks.
- Assert i_Reset at step 0100, count 00000100 → next clock step 0001, count 0, FETCH, error 0.
